video_pattern_generator: RTL and testbench

Parametrised successor to the fixed 1080p60 test source. Generates a complete video raster (hsync, vsync, de, 24-bit RGB) from one pixel clock, with all timings and sync polarity set by parameters and four run-time-selectable test patterns. It sits upstream of the HDMI/DVI encoder and replaces the single-pattern generator in test and bring-up builds.

---
 rtl/video_timing_pkg.sv | 57 +++++
 rtl/video_timing_counter.sv | 81 ++++++++
 rtl/video_pattern_generator.sv | 114 +++++++++++
 tb/tb_video_pattern_generator.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing sets, pattern-mode encodings and pixel helpers for the video test source.
// No logic of its own; latency and backpressure are set by the modules that use it.
package video_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fporch;
        int h_sync;
        int h_bporch;
        int v_active;
        int v_fporch;
        int v_sync;
        int v_bporch;
    } timing_t;

    localparam timing_t TIMING_1080P60 = '{
        h_active: 1920, h_fporch: 88, h_sync: 44, h_bporch: 148,
        v_active: 1080, v_fporch: 4,  v_sync: 5,  v_bporch: 36
    };

    localparam timing_t TIMING_720P60 = '{
        h_active: 1280, h_fporch: 110, h_sync: 40, h_bporch: 220,
        v_active: 720,  v_fporch: 5,   v_sync: 5,  v_bporch: 20
    };

    typedef enum logic [1:0] {
        PAT_MOVING_LINE = 2'd0,
        PAT_COLOUR_BARS = 2'd1,
        PAT_CHECKER     = 2'd2,
        PAT_GREY_RAMP   = 2'd3
    } pattern_mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_WHITE = 24'hFF_FF_FF;
    localparam rgb_t RGB_RED   = 24'hFF_00_00;
    localparam rgb_t RGB_BLACK = 24'h00_00_00;

    // Left edge of bar k; only ever called with constants, so it folds away.
    function automatic int bar_bound(input int k, input int h_active);
        return (k * h_active) / 8;
    endfunction

    // Bar order white..black: bit 2 kills green, bit 1 kills red, bit 0 kills blue.
    function automatic rgb_t bar_colour(input logic [2:0] bar);
        rgb_t c;
        c.r = {8{~bar[1]}};
        c.g = {8{~bar[2]}};
        c.b = {8{~bar[0]}};
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster timing: free-running hpos/vpos counters with registered hsync, vsync and data enable.
// Latency 1 clk from counter state to hsync/vsync/de; no backpressure, advances every cycle.
module video_timing_counter #(
    parameter int   H_ACTIVE    = 1920,
    parameter int   H_FPORCH    = 88,
    parameter int   H_SYNC      = 44,
    parameter int   H_BPORCH    = 148,
    parameter int   V_ACTIVE    = 1080,
    parameter int   V_FPORCH    = 4,
    parameter int   V_SYNC      = 5,
    parameter int   V_BPORCH    = 36,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   HW          = 12,
    parameter int   VW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] hpos_o,
    output logic [VW-1:0] vpos_o,
    output logic          active_o,
    output logic          frame_first_o,
    output logic          frame_end_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          de_o
);
    localparam int H_TOTAL  = H_ACTIVE + H_FPORCH + H_SYNC + H_BPORCH;
    localparam int V_TOTAL  = V_ACTIVE + V_FPORCH + V_SYNC + V_BPORCH;
    localparam int HS_BEGIN = H_ACTIVE + H_FPORCH;
    localparam int HS_END   = HS_BEGIN + H_SYNC;
    localparam int VS_BEGIN = V_ACTIVE + V_FPORCH;
    localparam int VS_END   = VS_BEGIN + V_SYNC;

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          line_end;

    always_comb begin
        line_end      = (int'(hpos_q) == H_TOTAL - 1);
        frame_end_o   = line_end && (int'(vpos_q) == V_TOTAL - 1);
        frame_first_o = (hpos_q == '0) && (vpos_q == '0);
        active_o      = (int'(hpos_q) < H_ACTIVE) && (int'(vpos_q) < V_ACTIVE);

        hpos_d = line_end ? '0 : hpos_q + HW'(1);
        vpos_d = vpos_q;
        if (line_end) begin
            vpos_d = frame_end_o ? '0 : vpos_q + VW'(1);
        end

        // vsync depends on vpos only, so it spans whole lines including blanking.
        hsync_d = (int'(hpos_q) >= HS_BEGIN && int'(hpos_q) < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = (int'(vpos_q) >= VS_BEGIN && int'(vpos_q) < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        de_d    = active_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            de_q    <= 1'b0;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
        end
    end

    assign hpos_o  = hpos_q;
    assign vpos_o  = vpos_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign de_o    = de_q;

endmodule

// File: rtl/video_pattern_generator.sv
// Parametrised raster test source: sync, data enable and one of four RGB test patterns.
// Latency 1 clk from (hpos,vpos) to every output; no backpressure, one pixel per clock.
module video_pattern_generator
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = TIMING_1080P60.h_active,
    parameter int   H_FPORCH    = TIMING_1080P60.h_fporch,
    parameter int   H_SYNC      = TIMING_1080P60.h_sync,
    parameter int   H_BPORCH    = TIMING_1080P60.h_bporch,
    parameter int   V_ACTIVE    = TIMING_1080P60.v_active,
    parameter int   V_FPORCH    = TIMING_1080P60.v_fporch,
    parameter int   V_SYNC      = TIMING_1080P60.v_sync,
    parameter int   V_BPORCH    = TIMING_1080P60.v_bporch,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   HW          = 12,
    parameter int   VW          = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       frame_start
);
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic          active;
    logic          frame_first;
    logic          frame_end;

    video_timing_counter #(
        .H_ACTIVE    (H_ACTIVE),
        .H_FPORCH    (H_FPORCH),
        .H_SYNC      (H_SYNC),
        .H_BPORCH    (H_BPORCH),
        .V_ACTIVE    (V_ACTIVE),
        .V_FPORCH    (V_FPORCH),
        .V_SYNC      (V_SYNC),
        .V_BPORCH    (V_BPORCH),
        .SYNC_ACTIVE (SYNC_ACTIVE),
        .HW          (HW),
        .VW          (VW)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .hpos_o        (hpos),
        .vpos_o        (vpos),
        .active_o      (active),
        .frame_first_o (frame_first),
        .frame_end_o   (frame_end),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .de_o          (de)
    );

    pattern_mode_e mode_q, mode_d;
    logic [HW-1:0] lpos_q, lpos_d;
    rgb_t          rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic [2:0]    bar;

    always_comb begin
        // Pixel (0,0) already uses the mode being latched, so a change lands exactly on frame_start.
        mode_d = frame_first ? pattern_mode_e'(mode) : mode_q;

        lpos_d = lpos_q;
        if (frame_end) begin
            lpos_d = (int'(lpos_q) == H_ACTIVE - 1) ? '0 : lpos_q + HW'(1);
        end

        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(hpos) >= bar_bound(k, H_ACTIVE)) begin
                bar = 3'(k);
            end
        end

        rgb_d = RGB_BLACK;
        if (active) begin
            unique case (mode_d)
                PAT_MOVING_LINE: rgb_d = (hpos == lpos_q) ? RGB_WHITE : RGB_RED;
                PAT_COLOUR_BARS: rgb_d = bar_colour(bar);
                PAT_CHECKER:     rgb_d = (1'(hpos >> 5) ^ 1'(vpos >> 5)) ? RGB_WHITE : RGB_BLACK;
                PAT_GREY_RAMP:   rgb_d = {3{8'(hpos)}};
            endcase
        end

        frame_start_d = frame_first;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= PAT_MOVING_LINE;
            lpos_q        <= '0;
            rgb_q         <= RGB_BLACK;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            lpos_q        <= lpos_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_pattern_generator.sv
// Bench for video_pattern_generator: two small rasters checked pixel by pixel against a frame-level model.
module tb_video_pattern_generator;

    localparam int AHA = 16, AHF = 2, AHS = 3, AHB = 3;
    localparam int AVA = 8,  AVF = 1, AVS = 2, AVB = 1;
    localparam int AHT = AHA + AHF + AHS + AHB;
    localparam int AVT = AVA + AVF + AVS + AVB;
    localparam int AFR = AHT * AVT;

    localparam int BHA = 64, BHF = 2, BHS = 3, BHB = 3;
    localparam int BVA = 40, BVF = 1, BVS = 2, BVB = 1;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam int BFR = BHT * BVT;

    // {hsync, vsync, de, frame_start, r, g, b}
    localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
    localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode_a = 2'd0;
    logic [1:0] mode_b = 2'd2;

    logic       hsync_a, vsync_a, de_a, frame_start_a;
    logic [7:0] red_a, green_a, blue_a;
    logic       hsync_b, vsync_b, de_b, frame_start_b;
    logic [7:0] red_b, green_b, blue_b;

    logic [27:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {hsync_a, vsync_a, de_a, frame_start_a, red_a, green_a, blue_a};
    assign obs_b = {hsync_b, vsync_b, de_b, frame_start_b, red_b, green_b, blue_b};

    int n_checks = 0;
    int n_fail   = 0;
    int p_next   = 0;
    int cur_p    = 0;
    int fm_a     = 0;
    int fm_b     = 0;

    always #5 clk = ~clk;

    video_pattern_generator #(
        .H_ACTIVE(AHA), .H_FPORCH(AHF), .H_SYNC(AHS), .H_BPORCH(AHB),
        .V_ACTIVE(AVA), .V_FPORCH(AVF), .V_SYNC(AVS), .V_BPORCH(AVB),
        .SYNC_ACTIVE(1'b0), .HW(12), .VW(11)
    ) dut_a (
        .clk(clk), .rst(rst), .mode(mode_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .frame_start(frame_start_a)
    );

    video_pattern_generator #(
        .H_ACTIVE(BHA), .H_FPORCH(BHF), .H_SYNC(BHS), .H_BPORCH(BHB),
        .V_ACTIVE(BVA), .V_FPORCH(BVF), .V_SYNC(BVS), .V_BPORCH(BVB),
        .SYNC_ACTIVE(1'b0), .HW(12), .VW(11)
    ) dut_b (
        .clk(clk), .rst(rst), .mode(mode_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .frame_start(frame_start_b)
    );

    // Expected outputs for the p-th pixel clock after reset release, from the raster rules directly.
    function automatic logic [27:0] ref_pixel(input int p, input int ha, hf, hsw, hb,
                                              input int va, vf, vsw, vb, input int fm);
        int ht, vt, h, v, f;
        logic hs_n, vs_n, act, fs;
        logic [23:0] rgb;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        h    = p % ht;
        v    = (p / ht) % vt;
        f    = p / (ht * vt);
        hs_n = !(h >= ha + hf && h < ha + hf + hsw);
        vs_n = !(v >= va + vf && v < va + vf + vsw);
        act  = (h < ha) && (v < va);
        fs   = (p % (ht * vt)) == 0;
        rgb  = 24'h000000;
        if (act) begin
            case (fm)
                0:       rgb = (h == f % ha) ? 24'hFFFFFF : 24'hFF0000;
                1:       rgb = BAR_RGB[(8 * h) / ha];
                2:       rgb = (((h / 32) + (v / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
                default: rgb = {3{8'(h % 256)}};
            endcase
        end
        return {hs_n, vs_n, act, fs, rgb};
    endfunction

    // Advance one clock; the mode seen at a frame's first pixel holds for that whole frame.
    task automatic step();
        @(negedge clk);
        cur_p = p_next;
        p_next++;
        if (cur_p % AFR == 0) fm_a = int'(mode_a);
        if (cur_p % BFR == 0) fm_b = int'(mode_b);
        exp_a = ref_pixel(cur_p, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, fm_a);
        exp_b = ref_pixel(cur_p, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, fm_b);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_a !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_hold_a got=%h expected=%h", obs_a, RST_VEC);
        end
        n_checks++;
        if (obs_b !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_hold_b got=%h expected=%h", obs_b, RST_VEC);
        end
        rst    = 1'b0;
        p_next = 0;
        #1;
        n_checks++;
        if (obs_a !== RST_VEC) begin
            n_fail++;
            $display("FAIL release_cycle0 got=%h expected=%h", obs_a, RST_VEC);
        end
        step();
        n_checks++;
        if (obs_a !== exp_a) begin
            n_fail++;
            $display("FAIL first_pixel p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
        end
        n_checks++;
        if ({hsync_a, vsync_a, de_a, frame_start_a, red_a, green_a, blue_a} !== {4'b1111, 24'hFFFFFF}) begin
            n_fail++;
            $display("FAIL first_pixel_fields got=%h expected=%h", obs_a, {4'b1111, 24'hFFFFFF});
        end
    endtask

    task automatic test_free_run();
        int de_cnt, hs_low, vs_low, fs_cnt, last_fs;
        de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; last_fs = -1;
        while (p_next % AFR != 0) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL align_raster p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
        end
        for (int i = 0; i < 2 * AFR; i++) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL free_run p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
            de_cnt += int'(de_a);
            hs_low += int'(!hsync_a);
            vs_low += int'(!vsync_a);
            if (frame_start_a) begin
                if (last_fs >= 0) begin
                    n_checks++;
                    if (cur_p - last_fs != AFR) begin
                        n_fail++;
                        $display("FAIL frame_period got=%0d expected=%0d", cur_p - last_fs, AFR);
                    end
                end
                last_fs = cur_p;
                fs_cnt++;
            end
        end
        n_checks++;
        if (de_cnt != 2 * AVA * AHA) begin
            n_fail++;
            $display("FAIL de_count got=%0d expected=%0d", de_cnt, 2 * AVA * AHA);
        end
        n_checks++;
        if (hs_low != 2 * AVT * AHS) begin
            n_fail++;
            $display("FAIL hsync_low_count got=%0d expected=%0d", hs_low, 2 * AVT * AHS);
        end
        n_checks++;
        if (vs_low != 2 * AVS * AHT) begin
            n_fail++;
            $display("FAIL vsync_low_count got=%0d expected=%0d", vs_low, 2 * AVS * AHT);
        end
        n_checks++;
        if (fs_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_start_count got=%0d expected=2", fs_cnt);
        end
    endtask

    task automatic test_moving_line();
        int h, v, f;
        mode_a = 2'd0;
        for (int i = 0; i < 16 * AFR; i++) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL moving_line p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
            h = cur_p % AHT;
            v = (cur_p / AHT) % AVT;
            f = cur_p / AFR;
            if (v == 0 && h == f % AHA) begin
                n_checks++;
                if ({red_a, green_a, blue_a} !== 24'hFFFFFF) begin
                    n_fail++;
                    $display("FAIL white_at_lpos frame=%0d h=%0d got=%h expected=ffffff",
                             f, h, {red_a, green_a, blue_a});
                end
            end
        end
    endtask

    task automatic test_bars_midframe();
        int h, v;
        logic [23:0] want;
        for (int i = 0; i < 100 + $urandom_range(0, 60); i++) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL pre_bars p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
        end
        mode_a = 2'd1;
        while (p_next % AFR != 0) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL bars_old_frame p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
        end
        for (int i = 0; i < AFR; i++) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL bars_frame p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
            h = cur_p % AHT;
            v = (cur_p / AHT) % AVT;
            if (v == 0 && h < AHA) begin
                want = BAR_RGB[h / 2];
                n_checks++;
                if ({red_a, green_a, blue_a} !== want) begin
                    n_fail++;
                    $display("FAIL bar_colour h=%0d got=%h expected=%h", h, {red_a, green_a, blue_a}, want);
                end
            end
        end
    endtask

    task automatic test_grey_ramp();
        int h;
        mode_a = 2'd3;
        for (int i = 0; i < 2 * AFR; i++) begin
            step();
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL grey_ramp p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
            h = cur_p % AHT;
            if (!de_a) begin
                n_checks++;
                if ({red_a, green_a, blue_a} !== 24'h000000) begin
                    n_fail++;
                    $display("FAIL blank_rgb p=%0d h=%0d got=%h expected=000000", cur_p, h, {red_a, green_a, blue_a});
                end
            end
        end
    endtask

    task automatic test_checkerboard();
        int h, v;
        logic [23:0] want;
        mode_b = 2'd2;
        while (p_next % BFR != 0) step();
        for (int i = 0; i < BFR; i++) begin
            step();
            n_checks++;
            if (obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL checker p=%0d got=%h expected=%h", cur_p, obs_b, exp_b);
            end
            h = cur_p % BHT;
            v = (cur_p / BHT) % BVT;
            if ((v == 0 || v == 32) && h < BHA) begin
                want = ((h >= 32) != (v == 32)) ? 24'hFFFFFF : 24'h000000;
                n_checks++;
                if ({red_b, green_b, blue_b} !== want) begin
                    n_fail++;
                    $display("FAIL checker_square v=%0d h=%0d got=%h expected=%h",
                             v, h, {red_b, green_b, blue_b}, want);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int  n;
        logic found;
        found = 1'b0;
        mode_a = 2'd0;
        n = 0;
        while (!found && n < AFR + 1) begin
            step();
            n++;
            found = (cur_p % AHT == 10) && ((cur_p / AHT) % AVT == 3);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_align_timeout got=%0d cycles expected<=%0d", n, AFR);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs_a !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset_a got=%h expected=%h", obs_a, RST_VEC);
        end
        n_checks++;
        if (obs_b !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset_b got=%h expected=%h", obs_b, RST_VEC);
        end
        @(negedge clk);
        rst    = 1'b0;
        p_next = 0;
        #1;
        n_checks++;
        if (obs_a !== RST_VEC) begin
            n_fail++;
            $display("FAIL rerelease_cycle0 got=%h expected=%h", obs_a, RST_VEC);
        end
        step();
        n_checks++;
        if (!(de_a === 1'b1 && frame_start_a === 1'b1)) begin
            n_fail++;
            $display("FAIL restart_frame_start got de=%b fs=%b expected de=1 fs=1", de_a, frame_start_a);
        end
        for (int i = 0; i < AFR + 4; i++) begin
            n_checks++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL after_rst p=%0d got=%h expected=%h", cur_p, obs_a, exp_a);
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        test_reset();
        test_free_run();
        test_moving_line();
        test_bars_midframe();
        test_grey_ramp();
        test_checkerboard();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
